// File: rtl/fifo_pkg.sv
// fifo_pkg: shared sizing helpers and constants for the fifo block.
// FIFO_PARITY_EN adds one even-parity bit per stored word.
`default_nettype none

package fifo_pkg;

    localparam int FIFO_DEPTH_DFLT = 16;
    localparam int HALF_THRESHOLD  = FIFO_DEPTH_DFLT / 2;

`ifdef FIFO_PARITY_EN
    localparam int PARITY_W = 1;
`else
    localparam int PARITY_W = 0;
`endif

    // Extra MSB lets equal low bits mean either empty or full.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int half_threshold(input int depth);
        return depth / 2;
    endfunction

    localparam int PTR_W_DFLT = ptr_width(FIFO_DEPTH_DFLT);

endpackage

`default_nettype wire

// File: rtl/fifo_sdpram.sv
// Simple dual-port RAM: core (sdpram) plus wrapper (fifo_sdpram).
// One write port and one enabled, registered read port. There is no reset.
`default_nettype none

module sdpram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_array [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_array[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_array[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

module fifo_sdpram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    // Inner name matches the wrapper's so backdoor paths stay stable.
    sdpram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) sdpram_i1 (
        .clk_i   (clk_i),
        .we_i    (we_i),
        .waddr_i (waddr_i),
        .wdata_i (wdata_i),
        .re_i    (re_i),
        .raddr_i (raddr_i),
        .rdata_o (rdata_o)
    );

endmodule

`default_nettype wire

// File: rtl/fifo.sv
// fifo: single-clock FIFO with active-low status flags and a sticky error flag.
// Define FIFO_PARITY_EN to store a parity bit per word and flag read parity errors.
`default_nettype none

module fifo
    import fifo_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  Clock,
    input  logic                  Reset_,
    input  logic                  WriteEn,
    input  logic [DATA_WIDTH-1:0] DataIn,
    input  logic                  ReadEn,
    output logic [DATA_WIDTH-1:0] DataOut,
    output logic                  Empty_,
    output logic                  HalfFull_,
    output logic                  Full_,
    output logic                  Error_
);

    localparam int PTR_W    = ptr_width(FIFO_DEPTH);
    localparam int ADDR_W   = PTR_W - 1;
    localparam int HALF_LVL = half_threshold(FIFO_DEPTH);
    localparam int RAM_W    = DATA_WIDTH + PARITY_W;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] count_d;
    logic             empty_n_q, empty_n_d;
    logic             half_n_q, half_n_d;
    logic             full_n_q, full_n_d;
    logic             error_n_q, error_n_d;
    logic             dout_vld_q, dout_vld_d;

    logic             wr_acc, rd_acc;
    logic             overflow, underflow, par_err;
    logic [RAM_W-1:0] ram_wdata, ram_rdata;

    // Registered flags already describe the current count, so they gate acceptance.
    assign wr_acc    = WriteEn & full_n_q;
    assign rd_acc    = ReadEn  & empty_n_q;
    assign overflow  = WriteEn & ~full_n_q;
    assign underflow = ReadEn  & ~empty_n_q;

`ifdef FIFO_PARITY_EN
    logic par_chk_q;

    assign ram_wdata = {^DataIn, DataIn};
    // Parity is checked the cycle the read word appears at the RAM output.
    assign par_err   = par_chk_q & (^ram_rdata);

    always_ff @(posedge Clock or negedge Reset_) begin
        if (!Reset_) begin
            par_chk_q <= 1'b0;
        end else begin
            par_chk_q <= rd_acc;
        end
    end
`else
    assign ram_wdata = DataIn;
    assign par_err   = 1'b0;
`endif

    always_comb begin
        wr_ptr_d   = wr_ptr_q + PTR_W'(wr_acc);
        rd_ptr_d   = rd_ptr_q + PTR_W'(rd_acc);
        count_d    = wr_ptr_d - rd_ptr_d;
        empty_n_d  = (count_d != '0);
        half_n_d   = (count_d < PTR_W'(HALF_LVL));
        full_n_d   = (count_d != PTR_W'(FIFO_DEPTH));
        error_n_d  = error_n_q & ~(overflow | underflow | par_err);
        dout_vld_d = dout_vld_q | rd_acc;
    end

    always_ff @(posedge Clock or negedge Reset_) begin
        if (!Reset_) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            empty_n_q  <= 1'b0;
            half_n_q   <= 1'b1;
            full_n_q   <= 1'b1;
            error_n_q  <= 1'b1;
            dout_vld_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            empty_n_q  <= empty_n_d;
            half_n_q   <= half_n_d;
            full_n_q   <= full_n_d;
            error_n_q  <= error_n_d;
            dout_vld_q <= dout_vld_d;
        end
    end

    fifo_sdpram #(
        .DATA_W (RAM_W),
        .ADDR_W (ADDR_W)
    ) sdpram_i1 (
        .clk_i   (Clock),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q[ADDR_W-1:0]),
        .wdata_i (ram_wdata),
        .re_i    (rd_acc),
        .raddr_i (rd_ptr_q[ADDR_W-1:0]),
        .rdata_o (ram_rdata)
    );

    // The RAM register has no reset; mask it to zero until the first real read.
    assign DataOut   = dout_vld_q ? ram_rdata[DATA_WIDTH-1:0] : '0;
    assign Empty_    = empty_n_q;
    assign HalfFull_ = half_n_q;
    assign Full_     = full_n_q;
    assign Error_    = error_n_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo.sv
// tb_fifo: directed self-checking bench for the fifo block.
`default_nettype none

module tb_fifo;

    logic        Clock;
    logic        Reset_;
    logic        WriteEn;
    logic [31:0] DataIn;
    logic        ReadEn;
    logic [31:0] DataOut;
    logic        Empty_;
    logic        HalfFull_;
    logic        Full_;
    logic        Error_;

    int vectors;
    int miscompares;

    fifo #(
        .FIFO_DEPTH (16),
        .DATA_WIDTH (32)
    ) dut (
        .Clock     (Clock),
        .Reset_    (Reset_),
        .WriteEn   (WriteEn),
        .DataIn    (DataIn),
        .ReadEn    (ReadEn),
        .DataOut   (DataOut),
        .Empty_    (Empty_),
        .HalfFull_ (HalfFull_),
        .Full_     (Full_),
        .Error_    (Error_)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then look at the outputs 1ns after the edge.
    task automatic step(input logic we, input logic [31:0] d, input logic re);
        WriteEn = we;
        DataIn  = d;
        ReadEn  = re;
        @(posedge Clock);
        #1;
        WriteEn = 1'b0;
        ReadEn  = 1'b0;
    endtask

    task automatic do_reset();
        WriteEn = 1'b0;
        ReadEn  = 1'b0;
        Reset_  = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        Reset_ = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        WriteEn     = 1'b0;
        ReadEn      = 1'b0;
        DataIn      = '0;
        Reset_      = 1'b1;
        #2;

        // Reset and idle
        do_reset();
        step(1'b0, 32'h0, 1'b0);
        chk_bit ("rst_empty", Empty_,    1'b0);
        chk_bit ("rst_half",  HalfFull_, 1'b1);
        chk_bit ("rst_full",  Full_,     1'b1);
        chk_bit ("rst_error", Error_,    1'b1);
        chk_word("rst_dout",  DataOut,   32'h0);

        // Three writes then three reads
        step(1'b1, 32'h11, 1'b0);
        step(1'b1, 32'h22, 1'b0);
        step(1'b1, 32'h33, 1'b0);
        chk_bit ("w3_empty", Empty_, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        chk_word("r1_dout", DataOut, 32'h11);
        step(1'b0, 32'h0, 1'b1);
        chk_word("r2_dout", DataOut, 32'h22);
        step(1'b0, 32'h0, 1'b1);
        chk_word("r3_dout", DataOut, 32'h33);
        chk_bit ("r3_empty", Empty_, 1'b0);
        chk_bit ("r3_error", Error_, 1'b1);

        // Fill to 16, checking half and full boundaries
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 32'h100 + 32'(i), 1'b0);
            if (i == 6)  chk_bit("half_at7",  HalfFull_, 1'b1);
            if (i == 7)  chk_bit("half_at8",  HalfFull_, 1'b0);
            if (i == 14) chk_bit("full_at15", Full_,     1'b1);
        end
        chk_bit("full_at16",  Full_,  1'b0);
        chk_bit("full_error", Error_, 1'b1);

        // Write while full with a concurrent read: read taken, write dropped
        step(1'b1, 32'hDEAD, 1'b1);
        chk_word("ovf_dout",  DataOut, 32'h100);
        chk_bit ("ovf_error", Error_,  1'b0);
        chk_bit ("ovf_full",  Full_,   1'b1);
        for (int i = 1; i < 16; i++) begin
            step(1'b0, 32'h0, 1'b1);
            chk_word("drain_dout", DataOut, 32'h100 + 32'(i));
        end
        chk_bit("drain_empty", Empty_, 1'b0);
        chk_bit("drain_error", Error_, 1'b0);

        // Underflow handling
        do_reset();
        chk_bit ("rst2_error", Error_,  1'b1);
        chk_word("rst2_dout",  DataOut, 32'h0);
        step(1'b1, 32'hA5, 1'b0);
        step(1'b0, 32'h0, 1'b1);
        chk_word("a5_dout",  DataOut, 32'hA5);
        chk_bit ("a5_error", Error_,  1'b1);
        step(1'b1, 32'h77, 1'b1);
        chk_word("udfw_dout",  DataOut, 32'hA5);
        chk_bit ("udfw_error", Error_,  1'b0);
        chk_bit ("udfw_empty", Empty_,  1'b1);
        step(1'b0, 32'h0, 1'b1);
        chk_word("r77_dout", DataOut, 32'h77);
        step(1'b0, 32'h0, 1'b1);
        chk_word("udf_dout", DataOut, 32'h77);
        repeat (3) step(1'b0, 32'h0, 1'b0);
        chk_bit("udf_sticky", Error_, 1'b0);

        // Streaming at count 5 across the storage wrap point
        do_reset();
        chk_bit("rst3_error", Error_, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 32'h200 + 32'(i), 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 32'h205 + 32'(i), 1'b1);
            chk_word("strm_dout", DataOut, 32'h200 + 32'(i));
            chk_bit ("strm_empty", Empty_,    1'b1);
            chk_bit ("strm_half",  HalfFull_, 1'b1);
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 32'h0, 1'b1);
            chk_word("strm_tail", DataOut, 32'h214 + 32'(i));
        end
        chk_bit("strm_end_empty", Empty_, 1'b0);
        chk_bit("strm_end_error", Error_, 1'b1);

        // Asynchronous reset at count 10
        for (int i = 0; i < 10; i++) step(1'b1, 32'h300 + 32'(i), 1'b0);
        chk_bit("c10_half", HalfFull_, 1'b0);
        #2;
        Reset_ = 1'b0;
        #1;
        chk_bit ("arst_empty", Empty_,    1'b0);
        chk_bit ("arst_half",  HalfFull_, 1'b1);
        chk_word("arst_dout",  DataOut,   32'h0);
        @(posedge Clock);
        #1;
        Reset_ = 1'b1;
        step(1'b1, 32'hBEEF, 1'b0);
        step(1'b0, 32'h0, 1'b1);
        chk_word("post_dout",  DataOut, 32'hBEEF);
        chk_bit ("post_empty", Empty_,  1'b0);
        chk_bit ("post_error", Error_,  1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
